// File: rtl/fpga_gpio_pkg.sv
// ----------------------------------------------------------------------------
// fpga_gpio_pkg
// Shared types and constants for the Caravel GPIO <-> FPGA fabric pad bridge.
//   pin_mode_t     : per-pin pad mode (input, push-pull output, open-drain, off)
//   bridge_state_t : serial configuration FSM states
//   CTRL_PINS      : number of top GPIO pins reserved for the config port
// ----------------------------------------------------------------------------
package fpga_gpio_pkg;

  localparam int unsigned CTRL_PINS = 3;

  // Pad mode encoding as it appears in the serial frame (2 bits per pin).
  typedef enum logic [1:0] {
    PM_IN  = 2'b00,
    PM_OUT = 2'b01,
    PM_OD  = 2'b10,
    PM_OFF = 2'b11
  } pin_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_SHIFT    = 2'b01,
    ST_COMMIT   = 2'b10,
    ST_OVERFLOW = 2'b11
  } bridge_state_t;

  // True when the pin's pad value is forwarded to the fabric.
  function automatic logic mode_passes_input(input pin_mode_t mode);
    return mode != PM_OFF;
  endfunction

endpackage : fpga_gpio_pkg

// File: rtl/gpio_sync.sv
// ----------------------------------------------------------------------------
// gpio_sync
// Multi-bit flop-chain synchroniser with a per-bit rising-edge pulse.
//   clk, rst : clock, asynchronous active-high reset
//   din      : asynchronous inputs (WIDTH bits)
//   sync_o   : synchronised inputs, STAGES cycles of latency
//   rise_c   : one-cycle pulse where sync_o went 0 -> 1 (decoded from flops)
// ----------------------------------------------------------------------------
module gpio_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_c
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]             prev_q, prev_d;

  // Shift chain: stage 0 samples the pad, the last stage is the clean value.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule : gpio_sync

// File: rtl/fpga_gpio_bridge.sv
// ----------------------------------------------------------------------------
// fpga_gpio_bridge
// GPIO-to-fabric pad bridge with a per-pin mode register loaded over a 3-pin
// serial port (data / strobe / commit on the top three GPIOs).
//   clk, rst   : clock, asynchronous active-high reset
//   en         : chip enable; low quiesces pads and the config FSM
//   gpio_in    : pad inputs; [NUM_GPIO-1]=cfg_data, [-2]=cfg_strobe,
//                [-3]=cfg_commit
//   gpio_out   : pad output values (registered)
//   gpio_oeb   : pad output enables, active-low (registered)
//   fab_in     : synchronised pad values toward the fabric
//   fab_out    : fabric values toward the pads
//   cfg_busy   : frame shift in progress (SHIFT or OVERFLOW)
//   cfg_done   : last commit accepted, cleared by the next strobe edge
//   cfg_err    : last commit rejected, cleared by the next strobe edge
// Build option: define FPGA_GPIO_PARITY_EN to append one even-parity bit to
// the frame; a parity mismatch rejects the commit.
// ----------------------------------------------------------------------------
module fpga_gpio_bridge
  import fpga_gpio_pkg::*;
#(
  parameter int unsigned NUM_GPIO    = 34,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_GPIO-1:0]           gpio_in,
  output logic [NUM_GPIO-1:0]           gpio_out,
  output logic [NUM_GPIO-1:0]           gpio_oeb,
  output logic [NUM_GPIO-CTRL_PINS-1:0] fab_in,
  input  logic [NUM_GPIO-CTRL_PINS-1:0] fab_out,
  output logic                          cfg_busy,
  output logic                          cfg_done,
  output logic                          cfg_err
);

  localparam int unsigned NUM_IO    = NUM_GPIO - CTRL_PINS;
  localparam int unsigned MODE_BITS = 2 * NUM_IO;
`ifdef FPGA_GPIO_PARITY_EN
  localparam int unsigned PAR_BITS  = 1;
`else
  localparam int unsigned PAR_BITS  = 0;
`endif
  localparam int unsigned FRAME_BITS = MODE_BITS + PAR_BITS;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

  // Control pin positions within the control synchroniser.
  localparam int unsigned C_COMMIT = 0;
  localparam int unsigned C_STROBE = 1;
  localparam int unsigned C_DATA   = 2;

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic [NUM_IO-1:0]    data_sync;
  logic [NUM_IO-1:0]    data_rise;
  logic [CTRL_PINS-1:0] ctrl_sync;
  logic [CTRL_PINS-1:0] ctrl_rise;

  gpio_sync #(
    .WIDTH  (NUM_IO),
    .STAGES (SYNC_STAGES)
  ) u_data_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (gpio_in[NUM_IO-1:0]),
    .sync_o (data_sync),
    .rise_c (data_rise)
  );

  gpio_sync #(
    .WIDTH  (CTRL_PINS),
    .STAGES (SYNC_STAGES)
  ) u_ctrl_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (gpio_in[NUM_GPIO-1 -: CTRL_PINS]),
    .sync_o (ctrl_sync),
    .rise_c (ctrl_rise)
  );

  logic cfg_data_s;
  logic strobe_rise;
  logic commit_rise;

  assign cfg_data_s  = ctrl_sync[C_DATA];
  assign strobe_rise = ctrl_rise[C_STROBE];
  assign commit_rise = ctrl_rise[C_COMMIT];

  // Edge pulses on data pins and levels of strobe/commit are not needed.
  logic unused_sync;
  assign unused_sync = ^{data_rise, ctrl_rise[C_DATA], ctrl_sync[C_STROBE], ctrl_sync[C_COMMIT]};

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  bridge_state_t          state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [FRAME_BITS-1:0]  shadow_q, shadow_d;
  logic [MODE_BITS-1:0]   active_q, active_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic [NUM_GPIO-1:0]    out_q, out_d;
  logic [NUM_GPIO-1:0]    oeb_q, oeb_d;
  logic [NUM_IO-1:0]      fab_mask_q, fab_mask_d;

  // --------------------------------------------------------------------------
  // Frame validation
  // --------------------------------------------------------------------------
  logic [MODE_BITS-1:0] shadow_modes;
  logic                 parity_ok;
  logic                 frame_ok;

  // Mode bits sit above the optional trailing parity bit.
  assign shadow_modes = shadow_q[FRAME_BITS-1 -: MODE_BITS];

`ifdef FPGA_GPIO_PARITY_EN
  // Even parity over mode bits plus the parity bit itself must be zero.
  assign parity_ok = ~(^shadow_q);
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_ok = (count_q == FRAME_CNT) && parity_ok;

  // --------------------------------------------------------------------------
  // Configuration FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    active_d = active_q;
    done_d   = done_q;
    err_d    = err_q;

    if (!en) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (commit_rise) begin
            // Commit with no frame in flight is always a reject.
            err_d  = 1'b1;
            done_d = 1'b0;
          end else if (strobe_rise) begin
            // The opening strobe edge already carries the first frame bit.
            shadow_d = {shadow_q[FRAME_BITS-2:0], cfg_data_s};
            count_d  = CNT_W'(1);
            done_d   = 1'b0;
            err_d    = 1'b0;
            state_d  = ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // Commit wins over a coincident strobe; that strobe bit is dropped.
          if (commit_rise) begin
            state_d = ST_COMMIT;
          end else if (strobe_rise) begin
            done_d = 1'b0;
            err_d  = 1'b0;
            if (count_q == FRAME_CNT) begin
              state_d = ST_OVERFLOW;
            end else begin
              shadow_d = {shadow_q[FRAME_BITS-2:0], cfg_data_s};
              count_d  = count_q + CNT_W'(1);
            end
          end
        end

        ST_COMMIT: begin
          if (frame_ok) begin
            active_d = shadow_modes;
            done_d   = 1'b1;
            err_d    = 1'b0;
          end else begin
            done_d   = 1'b0;
            err_d    = 1'b1;
          end
          count_d = '0;
          state_d = ST_IDLE;
        end

        ST_OVERFLOW: begin
          if (commit_rise) begin
            done_d  = 1'b0;
            err_d   = 1'b1;
            count_d = '0;
            state_d = ST_IDLE;
          end else if (strobe_rise) begin
            done_d = 1'b0;
            err_d  = 1'b0;
          end
        end

        default: begin
          count_d = '0;
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_SHIFT) || (state_d == ST_OVERFLOW);
  end

  // --------------------------------------------------------------------------
  // Pad drive decode from the active (never the shadow) mode register
  // --------------------------------------------------------------------------
  always_comb begin
    out_d      = '0;
    oeb_d      = '1;
    fab_mask_d = '0;

    if (en) begin
      for (int unsigned i = 0; i < NUM_IO; i++) begin
        pin_mode_t mode;
        mode          = pin_mode_t'(active_q[2*i +: 2]);
        fab_mask_d[i] = mode_passes_input(mode);
        unique case (mode)
          PM_OUT: begin
            oeb_d[i] = 1'b0;
            out_d[i] = fab_out[i];
          end
          // Open-drain: drive low when fabric drives 0, float otherwise.
          PM_OD: begin
            oeb_d[i] = fab_out[i];
            out_d[i] = 1'b0;
          end
          default: begin
            oeb_d[i] = 1'b1;
            out_d[i] = 1'b0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      out_q      <= '0;
      oeb_q      <= '1;
      fab_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      out_q      <= out_d;
      oeb_q      <= oeb_d;
      fab_mask_q <= fab_mask_d;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oeb = oeb_q;
  assign cfg_busy = busy_q;
  assign cfg_done = done_q;
  assign cfg_err  = err_q;

  // Last synchroniser stage gated by a registered per-pin mask keeps the
  // pad-to-fabric latency at SYNC_STAGES cycles.
  assign fab_in = data_sync & fab_mask_q;

endmodule : fpga_gpio_bridge
